// File: rtl/if_pc_redirect.sv
// Fetch PC register with ID-stage redirect, buffered across slow imem fetches.
// DELAY_SLOT_EN: keep the instruction after a branch (MIPS delay slot), no flush.
module if_pc_redirect #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          PC_W     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_valid,
  input  logic            br_taken,
  input  logic            is_jump,
  input  logic [PC_W-1:0] br_target,
  input  logic            imem_ready,
  output logic            imem_req,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic            if_flush,
  output logic            redirect_pending
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

`ifdef DELAY_SLOT_EN
  localparam logic KEEP_SLOT = 1'b1;
`else
  localparam logic KEEP_SLOT = 1'b0;
`endif

  logic [0:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_q, pend_d;
  logic [PC_W-1:0] target;
  logic            redirect;
  logic            flush;

  assign redirect = ~stall & br_valid & (is_jump | br_taken);
  assign target   = {br_target[PC_W-1:2], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    flush   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (redirect) begin
          if (imem_ready) begin
            pc_d  = target;
            flush = 1'b1;
          end else begin
            pend_d  = target;
            state_d = PEND;
          end
        end else if (imem_ready & ~stall) begin
          pc_d = pc_plus4;
        end
      end
      PEND: begin
        // Completes even under stall: flush overrides stall at IF/ID
        if (imem_ready) begin
          pc_d    = pend_q;
          flush   = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC[PC_W-1:0];
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  assign pc               = pc_q;
  assign pc_plus4         = pc_q + PC_W'(4);
  assign imem_req         = ~rst;
  assign if_flush         = ~rst & flush & ~KEEP_SLOT;
  assign redirect_pending = ~rst & (state_q == PEND);

endmodule
